fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; power of two, >= 4.
REQ-002 Parameter XLEN, default 32, instruction and PC width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  discard all entries (branch redirect).
REQ-006 in_valid  input  2  fetch slot valid; legal values 00, 01, 11 (slot 0 is older).
REQ-007 in_instr0, in_instr1  input  XLEN each  fetched instruction words.
REQ-008 in_pc0, in_pc1  input  XLEN each  PCs of the fetched instructions.
REQ-009 in_ready  output  1  queue accepts a 2-wide fetch this cycle.
REQ-010 out_valid  output  2  decode slot valid; only 00, 01, 11 ever driven.
REQ-011 out_instr0, out_instr1  output  XLEN each  oldest and second-oldest instruction, fed to decode/immediate extraction.
REQ-012 out_pc0, out_pc1  output  XLEN each  matching PCs.
REQ-013 deq  input  2  decode consumed slots; legal 00, 01, 11.
REQ-014 count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-015 Storage: circular buffer of DEPTH {instr, pc} entries, read pointer, write pointer, occupancy counter; pointers wrap modulo DEPTH.
REQ-016 in_ready = 1 iff registered count <= DEPTH-2; combinational from state only, never from same-cycle deq.
REQ-017 Enqueue when in_ready=1 and flush=0: in_valid=01 writes slot 0 at wptr, wptr+=1; 11 writes slot 0 at wptr, slot 1 at wptr+1, wptr+=2.
REQ-018 in_valid with in_ready=0 is dropped; no state change from the enqueue side.
REQ-019 in_valid=10 is illegal; it SHALL be treated as 00.
REQ-020 out_valid[0] = (count >= 1); out_valid[1] = (count >= 2); out slot 0 = entry at rptr, slot 1 = entry at rptr+1 (wrapped).
REQ-021 Output data fields SHALL read as zero when the matching out_valid bit is 0.
REQ-022 Read path is combinational (zero-latency lookahead); an entry written at edge N is visible on the outputs after edge N.
REQ-023 Dequeue: deq bits are masked by out_valid; effective deq count 0/1/2 advances rptr by that amount.
REQ-024 deq=10 is illegal and SHALL be treated as 00.
REQ-025 Simultaneous enqueue and dequeue in one cycle: count_next = count + enq_cnt - deq_cnt; both pointer updates apply.
REQ-026 flush=1: at the next edge rptr=wptr=0, count=0; same-cycle enqueue and dequeue are ignored.
REQ-027 count never exceeds DEPTH and never underflows; no entry is overwritten before it is dequeued.
REQ-028 Program order is preserved: dequeue order equals enqueue order, slot 0 before slot 1.

Reset
REQ-029 rst asserted: immediately (without waiting for clk) rptr=0, wptr=0, count=0, out_valid=00, outputs zero, in_ready=1.
REQ-030 rst mid-operation discards all entries; the first edge after deassertion behaves as an empty queue.
REQ-031 Storage array contents need no reset; they are masked by REQ-021.

Verification
REQ-032 After reset, enqueue {0x00500093 @0x0, 0x00A00113 @0x4} with deq=00 -> next cycle out_valid=11, out_instr0=0x00500093, out_pc1=0x4, count=2.
REQ-033 Fill with three 2-wide enqueues, no deq (count=6) -> in_ready=1; one more gives count=8 -> in_ready=0; a further 11 enqueue is dropped, count stays 8.
REQ-034 count=8 with deq=11 and in_valid=11 in the same cycle -> enqueue dropped (in_ready=0), count=6; the next cycle accepts the enqueue, count=8.
REQ-035 Wrap: run 20 alternating enqueue-2 / dequeue-1 / dequeue-2 cycles with sequential PCs -> dequeued PCs strictly increment by 4 and no entry is lost or duplicated.
REQ-036 count=5 with flush=1, in_valid=11, deq=01 -> next cycle count=0, out_valid=00, outputs zero, in_ready=1.
REQ-037 Assert rst asynchronously between edges at count=3 -> out_valid=00 and count=0 before the next clk edge.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side and decode-side handshake bundle for fetch_queue
interface fetch_queue_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic            flush;
  logic [1:0]      in_valid;
  logic [XLEN-1:0] in_instr0, in_instr1, in_pc0, in_pc1;
  logic            in_ready;
  logic [1:0]      out_valid;
  logic [XLEN-1:0] out_instr0, out_instr1, out_pc0, out_pc1;
  logic [1:0]      deq;
  logic [CW-1:0]   count;
  modport master (
    output flush, in_valid, in_instr0, in_instr1, in_pc0, in_pc1, deq,
    input  in_ready, out_valid, out_instr0, out_instr1, out_pc0, out_pc1, count
  );
  modport slave (
    input  flush, in_valid, in_instr0, in_instr1, in_pc0, in_pc1, deq,
    output in_ready, out_valid, out_instr0, out_instr1, out_pc0, out_pc1, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-wide in / 2-wide out circular instruction queue with flush
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d, rptr1, wptr1;
  logic [CW-1:0]   count_q, count_d;
  logic            rdy, v0, v1, wr0, wr1, rd0, rd1;
  // Ready looks only at registered occupancy so a full queue never depends on same-cycle deq
  assign rdy   = count_q <= CW'(DEPTH - 2);
  assign v0    = count_q >= CW'(1);
  assign v1    = count_q >= CW'(2);
  assign wr0   = rdy & ~fq.flush & fq.in_valid[0];
  assign wr1   = wr0 & fq.in_valid[1];
  assign rd0   = ~fq.flush & v0 & fq.deq[0];
  assign rd1   = rd0 & v1 & fq.deq[1];
  assign rptr1 = rptr_q + AW'(1);
  assign wptr1 = wptr_q + AW'(1);
  always_comb begin
    rptr_d  = fq.flush ? '0 : rptr_q + AW'(rd0) + AW'(rd1);
    wptr_d  = fq.flush ? '0 : wptr_q + AW'(wr0) + AW'(wr1);
    count_d = fq.flush ? '0 : count_q + CW'(wr0) + CW'(wr1) - CW'(rd0) - CW'(rd1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr0) begin
      instr_q[wptr_q] <= fq.in_instr0;
      pc_q[wptr_q]    <= fq.in_pc0;
    end
    if (wr1) begin
      instr_q[wptr1] <= fq.in_instr1;
      pc_q[wptr1]    <= fq.in_pc1;
    end
  end
  // Stale storage is masked so decode never sees garbage in empty slots
  assign fq.in_ready   = rdy;
  assign fq.out_valid  = {v1, v0};
  assign fq.out_instr0 = v0 ? instr_q[rptr_q] : '0;
  assign fq.out_pc0    = v0 ? pc_q[rptr_q] : '0;
  assign fq.out_instr1 = v1 ? instr_q[rptr1] : '0;
  assign fq.out_pc1    = v1 ? pc_q[rptr1] : '0;
  assign fq.count      = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, corner sequences and random traffic against a queue model
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  typedef struct {
    logic       fl;
    logic [1:0] iv;
    logic [1:0] dq;
    int         cnt;
    logic       rdy;
    logic [1:0] ov;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ent_t mq[$];
  logic [31:0] popped[$];
  logic [31:0] next_pc;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[15];
  fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) fq ();
  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clk(clk), .rst(rst), .fq(fq));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic check_all(input string tag);
    int sz = mq.size();
    chk({tag, " count"}, 64'(fq.count), 64'(sz));
    chk({tag, " in_ready"}, 64'(fq.in_ready), 64'(sz <= DEPTH - 2));
    chk({tag, " out_valid"}, 64'(fq.out_valid), 64'({sz >= 2, sz >= 1}));
    chk({tag, " out_instr0"}, 64'(fq.out_instr0), 64'(sz >= 1 ? mq[0].instr : 32'h0));
    chk({tag, " out_pc0"}, 64'(fq.out_pc0), 64'(sz >= 1 ? mq[0].pc : 32'h0));
    chk({tag, " out_instr1"}, 64'(fq.out_instr1), 64'(sz >= 2 ? mq[1].instr : 32'h0));
    chk({tag, " out_pc1"}, 64'(fq.out_pc1), 64'(sz >= 2 ? mq[1].pc : 32'h0));
  endtask
  task automatic idle();
    fq.flush = 1'b0;
    fq.in_valid = 2'b00;
    fq.deq = 2'b00;
    fq.in_instr0 = '0;
    fq.in_instr1 = '0;
    fq.in_pc0 = '0;
    fq.in_pc1 = '0;
  endtask
  task automatic step(input logic fl, input logic [1:0] iv, input logic [1:0] dq,
                      input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1, input string tag);
    int  sz = mq.size();
    bit  rdy = sz <= DEPTH - 2;
    int  n = dq[0] ? (dq[1] ? 2 : 1) : 0;
    ent_t e0, e1;
    e0.instr = i0; e0.pc = p0;
    e1.instr = i1; e1.pc = p1;
    if (n > sz) n = sz;
    fq.flush = fl;
    fq.in_valid = iv;
    fq.deq = dq;
    fq.in_instr0 = i0;
    fq.in_pc0 = p0;
    fq.in_instr1 = i1;
    fq.in_pc1 = p1;
    if (!fl && n >= 1) popped.push_back(fq.out_pc0);
    if (!fl && n == 2) popped.push_back(fq.out_pc1);
    @(posedge clk);
    #1;
    if (fl) mq.delete();
    else begin
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      if (rdy && iv[0]) mq.push_back(e0);
      if (rdy && iv == 2'b11) mq.push_back(e1);
    end
    check_all(tag);
  endtask
  task automatic seq_step(input logic fl, input logic [1:0] iv, input logic [1:0] dq, input string tag);
    logic [31:0] p0 = next_pc;
    logic [31:0] p1 = next_pc + 32'd4;
    if (!fl && mq.size() <= DEPTH - 2 && iv[0]) next_pc += (iv == 2'b11) ? 32'd8 : 32'd4;
    step(fl, iv, dq, p0 * 3 + 32'h13, p0, p1 * 3 + 32'h13, p1, tag);
  endtask
  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    mq.delete();
    next_pc = 0;
    check_all("reset");
    #1;
    rst = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{1'b0, 2'b11, 2'b00, 4, 1'b1, 2'b11};
    tbl[1]  = '{1'b0, 2'b11, 2'b00, 6, 1'b1, 2'b11};
    tbl[2]  = '{1'b0, 2'b11, 2'b00, 8, 1'b0, 2'b11};
    tbl[3]  = '{1'b0, 2'b11, 2'b00, 8, 1'b0, 2'b11};
    tbl[4]  = '{1'b0, 2'b11, 2'b11, 6, 1'b1, 2'b11};
    tbl[5]  = '{1'b0, 2'b11, 2'b00, 8, 1'b0, 2'b11};
    tbl[6]  = '{1'b0, 2'b00, 2'b11, 6, 1'b1, 2'b11};
    tbl[7]  = '{1'b0, 2'b00, 2'b10, 6, 1'b1, 2'b11};
    tbl[8]  = '{1'b0, 2'b10, 2'b01, 5, 1'b1, 2'b11};
    tbl[9]  = '{1'b1, 2'b11, 2'b01, 0, 1'b1, 2'b00};
    tbl[10] = '{1'b0, 2'b00, 2'b11, 0, 1'b1, 2'b00};
    tbl[11] = '{1'b0, 2'b01, 2'b00, 1, 1'b1, 2'b01};
    tbl[12] = '{1'b0, 2'b00, 2'b11, 0, 1'b1, 2'b00};
    tbl[13] = '{1'b0, 2'b01, 2'b00, 1, 1'b1, 2'b01};
    tbl[14] = '{1'b0, 2'b11, 2'b00, 3, 1'b1, 2'b11};
    do_reset();
    step(1'b0, 2'b11, 2'b00, 32'h00500093, 32'h0, 32'h00A00113, 32'h4, "first");
    chk("first out_instr0 const", 64'(fq.out_instr0), 64'h00500093);
    chk("first out_pc1 const", 64'(fq.out_pc1), 64'h4);
    chk("first count const", 64'(fq.count), 64'd2);
    chk("first out_valid const", 64'(fq.out_valid), 64'b11);
    next_pc = 32'd8;
    for (int i = 0; i < 15; i++) begin
      seq_step(tbl[i].fl, tbl[i].iv, tbl[i].dq, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl count", i), 64'(fq.count), 64'(tbl[i].cnt));
      chk($sformatf("vec%0d tbl in_ready", i), 64'(fq.in_ready), 64'(tbl[i].rdy));
      chk($sformatf("vec%0d tbl out_valid", i), 64'(fq.out_valid), 64'(tbl[i].ov));
    end
    idle();
    #2 rst = 1'b1;
    #1;
    chk("async count", 64'(fq.count), 64'd0);
    chk("async out_valid", 64'(fq.out_valid), 64'd0);
    chk("async in_ready", 64'(fq.in_ready), 64'd1);
    chk("async out_pc0", 64'(fq.out_pc0), 64'd0);
    #1 rst = 1'b0;
    mq.delete();
    next_pc = 0;
    seq_step(1'b0, 2'b01, 2'b01, "post_rst");
    chk("post_rst count", 64'(fq.count), 64'd1);
    do_reset();
    popped.delete();
    for (int i = 0; i < 20; i++) seq_step(1'b0, 2'b11, (i % 2) ? 2'b11 : 2'b01, $sformatf("wrap%0d", i));
    for (int i = 0; i < 6; i++) seq_step(1'b0, 2'b00, 2'b11, $sformatf("drain%0d", i));
    chk("wrap popped total", 64'(popped.size()), 64'(next_pc / 4));
    for (int k = 0; k < popped.size(); k++) chk($sformatf("wrap pc%0d", k), 64'(popped[k]), 64'(k * 4));
    for (int i = 0; i < 400; i++) begin
      int a = $urandom_range(7);
      int b = $urandom_range(7);
      logic [1:0] iv = (a < 2) ? 2'b00 : (a == 2) ? 2'b10 : (a < 5) ? 2'b01 : 2'b11;
      logic [1:0] dq = (b < 2) ? 2'b00 : (b == 2) ? 2'b10 : (b < 5) ? 2'b01 : 2'b11;
      step($urandom_range(15) == 0, iv, dq, $urandom, $urandom, $urandom, $urandom, $sformatf("rnd%0d", i));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
